// File: rtl/risc_cpu_with_peripherals_sys.sv
//------------------------------------------------------------------------------
// Module   : risc_cpu_with_peripherals_sys
// Brief    : 8-bit accumulator CPU with 8K program ROM and 1K data RAM on a
//            shared 13-bit address / 8-bit data bus; one instruction per 8 clks.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cpu_sm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] i_operation,
    output logic [2:0] o_state,
    output logic       o_wr
);
    localparam int         CLK_PER_INSTR = 8;
    localparam int         STATE_W       = $clog2(CLK_PER_INSTR);
    localparam logic [2:0] c_OP_STO      = 3'd6;

    typedef enum logic [STATE_W-1:0] {
        S0 = 3'd0, S1 = 3'd1, S2 = 3'd2, S3 = 3'd3,
        S4 = 3'd4, S5 = 3'd5, S6 = 3'd6, S7 = 3'd7
    } state_t;

    state_t state;
    logic   r_wr;

    // wr is registered so it is high for exactly the S5 cycle of a store
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state <= S0;
            r_wr  <= 1'b0;
        end else begin
            state <= state_t'(state + 3'd1);
            r_wr  <= (state == S4) && (i_operation == c_OP_STO);
        end
    end

    assign o_state = state;
    assign o_wr    = r_wr;
endmodule

module cpu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  i_mem_data,
    output logic [12:0] o_addr,
    output logic        o_wr,
    output logic [7:0]  o_data
);
    localparam logic [2:0] c_OP_SKZ = 3'd1;
    localparam logic [2:0] c_OP_ADD = 3'd2;
    localparam logic [2:0] c_OP_AND = 3'd3;
    localparam logic [2:0] c_OP_XOR = 3'd4;
    localparam logic [2:0] c_OP_LDA = 3'd5;
    localparam logic [2:0] c_OP_JMP = 3'd7;

    localparam logic [2:0] c_S0 = 3'd0;
    localparam logic [2:0] c_S1 = 3'd1;
    localparam logic [2:0] c_S3 = 3'd3;
    localparam logic [2:0] c_S4 = 3'd4;

    logic [15:0] ir;
    logic [12:0] pc;
    logic [7:0]  accu;
    logic [7:0]  r_operand;
    logic [7:0]  data;
    logic [7:0]  alu_out;
    logic [2:0]  operation;
    logic [2:0]  w_state;
    logic        wr;

    cpu_sm cpu_sm (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_operation (operation),
        .o_state     (w_state),
        .o_wr        (wr)
    );

    assign operation = ir[15:13];
    assign data      = wr ? accu : i_mem_data;
    // Operand address is held from decode through the store cycle
    assign o_addr    = (w_state >= 3'd2 && w_state <= 3'd5) ? ir[12:0] : pc;
    assign o_wr      = wr;
    assign o_data    = data;

    always_comb begin
        alu_out = accu;
        case (operation)
            c_OP_ADD: alu_out = accu + r_operand;
            c_OP_AND: alu_out = accu & r_operand;
            c_OP_XOR: alu_out = accu ^ r_operand;
            c_OP_LDA: alu_out = r_operand;
            default:  alu_out = accu;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            ir        <= 16'd0;
            pc        <= 13'd0;
            accu      <= 8'd0;
            r_operand <= 8'd0;
        end else begin
            case (w_state)
                c_S0: begin
                    ir[15:8] <= data;
                    pc       <= pc + 13'd1;
                end
                c_S1: begin
                    ir[7:0] <= data;
                    pc      <= pc + 13'd1;
                end
                c_S3: r_operand <= data;
                c_S4: begin
                    case (operation)
                        c_OP_ADD, c_OP_AND, c_OP_XOR, c_OP_LDA: accu <= alu_out;
                        c_OP_SKZ: if (accu == 8'd0) pc <= pc + 13'd2;
                        c_OP_JMP: pc <= ir[12:0];
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end
endmodule

module rom (
    input  logic [12:0] i_addr,
    output logic [7:0]  o_data
);
    localparam int ROM_DEPTH = 8192;

    logic [7:0] mem [0:ROM_DEPTH-1];

    assign o_data = mem[i_addr];
endmodule

module ram (
    input  logic       clk,
    input  logic [9:0] i_addr,
    input  logic       i_we,
    input  logic [7:0] i_wdata,
    output logic [7:0] o_data
);
    localparam int RAM_DEPTH = 1024;

    logic [7:0] mem [0:RAM_DEPTH-1];

    always_ff @(posedge clk) begin
        if (i_we) mem[i_addr] <= i_wdata;
    end

    assign o_data = mem[i_addr];
endmodule

module risc_cpu_with_peripherals_sys (
    input  logic clk,
    input  logic rst_n
);
    logic [12:0] addr;
    logic        ram_en;
    logic        wr;
    logic [7:0]  w_cpu_data;
    logic [7:0]  w_rom_data;
    logic [7:0]  w_ram_data;
    logic [7:0]  w_mem_data;

    // RAM occupies 0x1800-0x1FFF and mirrors every 1K inside that window
    assign ram_en     = (addr[12:11] == 2'b11);
    assign w_mem_data = ram_en ? w_ram_data : w_rom_data;

    cpu cpu (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_mem_data (w_mem_data),
        .o_addr     (addr),
        .o_wr       (wr),
        .o_data     (w_cpu_data)
    );

    rom rom (
        .i_addr (addr),
        .o_data (w_rom_data)
    );

    ram ram (
        .clk     (clk),
        .i_addr  (addr[9:0]),
        .i_we    (wr & ram_en),
        .i_wdata (w_cpu_data),
        .o_data  (w_ram_data)
    );
endmodule

`default_nettype wire

// File: tb/tb_risc_cpu_with_peripherals_sys.sv
//------------------------------------------------------------------------------
// Module   : tb_risc_cpu_with_peripherals_sys
// Brief    : Directed programs with hand-computed results for the CPU system.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_risc_cpu_with_peripherals_sys;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    int   wr_hits;
    bit   found;

    risc_cpu_with_peripherals_sys dut (
        .clk   (clk),
        .rst_n (rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            if (dut.wr === 1'b1) wr_hits++;
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 8192; i++) dut.rom.mem[i] = 8'h00;
    endtask

    task automatic load4(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                         input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5,
                         input logic [7:0] b6, input logic [7:0] b7);
        clear_rom();
        dut.rom.mem[0] = b0; dut.rom.mem[1] = b1;
        dut.rom.mem[2] = b2; dut.rom.mem[3] = b3;
        dut.rom.mem[4] = b4; dut.rom.mem[5] = b5;
        dut.rom.mem[6] = b6; dut.rom.mem[7] = b7;
    endtask

    // Two-cycle reset; returns on a falling edge just after release
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(2);
        rst_n = 1'b0;
    endtask

    task automatic wait_mem2(input logic [7:0] exp, input int budget);
        found = 0;
        for (int i = 0; i < budget && !found; i++) begin
            step(1);
            if (dut.ram.mem[2] === exp) found = 1;
        end
    endtask

    task automatic wait_state(input logic [2:0] st, input logic [2:0] op, input int budget);
        found = 0;
        for (int i = 0; i < budget && !found; i++) begin
            step(1);
            if (dut.cpu.cpu_sm.state == st && dut.cpu.operation === op) found = 1;
        end
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        wr_hits = 0;
        rst_n   = 1'b1;

        // Test 1: 5 + 3 stored to RAM[2]
        load4(8'hB8, 8'h00, 8'h58, 8'h01, 8'hD8, 8'h02, 8'hE0, 8'h06);
        dut.ram.mem[0] = 8'h05; dut.ram.mem[1] = 8'h03; dut.ram.mem[2] = 8'h00;
        step(2);
        check("rst_state", 16'(dut.cpu.cpu_sm.state), 16'h0);
        check("rst_pc", 16'(dut.cpu.pc), 16'h0);
        check("rst_ir", dut.cpu.ir, 16'h0);
        check("rst_accu", 16'(dut.cpu.accu), 16'h0);
        check("rst_wr", 16'(dut.wr), 16'h0);
        do_reset();
        step(2);
        check("t1_fetch_ir", dut.cpu.ir, 16'hB800);
        check("t1_fetch_pc", 16'(dut.cpu.pc), 16'h2);
        wait_mem2(8'h08, 22);
        check("t1_sto_in_time", 16'(found), 16'h1);
        check("t1_mem2", 16'(dut.ram.mem[2]), 16'h08);
        step(40);
        check("t1_mem2_hold", 16'(dut.ram.mem[2]), 16'h08);
        check("t1_loop_op", 16'(dut.cpu.operation), 16'h7);
        check("t1_accu", 16'(dut.cpu.accu), 16'h08);

        // Test 2: ADD wraps, carry dropped
        dut.ram.mem[0] = 8'hFF; dut.ram.mem[1] = 8'h02; dut.ram.mem[2] = 8'h00;
        do_reset();
        step(24);
        check("t2_add_wrap", 16'(dut.ram.mem[2]), 16'h01);

        // Test 3: AND then XOR
        dut.rom.mem[2] = 8'h78;
        dut.ram.mem[0] = 8'hF0; dut.ram.mem[1] = 8'h3C; dut.ram.mem[2] = 8'h00;
        do_reset();
        step(24);
        check("t3_and", 16'(dut.ram.mem[2]), 16'h30);
        dut.rom.mem[2] = 8'h98;
        dut.ram.mem[2] = 8'h00;
        do_reset();
        step(24);
        check("t3_xor", 16'(dut.ram.mem[2]), 16'hCC);

        // Test 4: SKZ skips the store when the loaded byte is zero
        load4(8'hB8, 8'h00, 8'h20, 8'h00, 8'hD8, 8'h02, 8'hE0, 8'h06);
        dut.ram.mem[0] = 8'h00; dut.ram.mem[2] = 8'hAA;
        do_reset();
        step(40);
        check("t4_skz_taken", 16'(dut.ram.mem[2]), 16'hAA);
        check("t4_skz_loop_op", 16'(dut.cpu.operation), 16'h7);
        dut.ram.mem[0] = 8'h11;
        do_reset();
        step(40);
        check("t4_skz_not_taken", 16'(dut.ram.mem[2]), 16'h11);

        // Test 5: reset during S4 of a store aborts it
        load4(8'hB8, 8'h00, 8'h58, 8'h01, 8'hD8, 8'h02, 8'hE0, 8'h06);
        dut.ram.mem[0] = 8'h05; dut.ram.mem[1] = 8'h03; dut.ram.mem[2] = 8'hAA;
        do_reset();
        wait_state(3'd4, 3'd6, 40);
        check("t5_reach_s4", 16'(found), 16'h1);
        rst_n   = 1'b1;
        wr_hits = 0;
        step(1);
        check("t5_state", 16'(dut.cpu.cpu_sm.state), 16'h0);
        check("t5_pc", 16'(dut.cpu.pc), 16'h0);
        check("t5_accu", 16'(dut.cpu.accu), 16'h0);
        check("t5_wr", 16'(dut.wr), 16'h0);
        step(3);
        rst_n = 1'b0;
        check("t5_addr", 16'(dut.addr), 16'h0);
        step(2);
        check("t5_refetch_ir", dut.cpu.ir, 16'hB800);
        check("t5_wr_hits", 16'(wr_hits), 16'h0);
        check("t5_mem2", 16'(dut.ram.mem[2]), 16'hAA);

        // Test 6: store into ROM range is ignored
        load4(8'hB8, 8'h00, 8'hC0, 8'h02, 8'hE0, 8'h04, 8'h00, 8'h00);
        dut.ram.mem[0] = 8'h5A; dut.ram.mem[2] = 8'h77;
        do_reset();
        wait_state(3'd5, 3'd6, 40);
        check("t6_reach_s5", 16'(found), 16'h1);
        check("t6_wr", 16'(dut.wr), 16'h1);
        check("t6_ram_en", 16'(dut.ram_en), 16'h0);
        check("t6_addr", 16'(dut.addr), 16'h0002);
        step(10);
        check("t6_rom_kept", 16'(dut.rom.mem[2]), 16'h00C0);
        check("t6_ram_kept", 16'(dut.ram.mem[2]), 16'h0077);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/risc_cpu_with_peripherals_sys.md
Name: risc_cpu_with_peripherals_sys

Overview:
Top-level system containing an 8-bit accumulator RISC CPU, an 8K x 8 program ROM and a 1K x 8 data RAM on a shared 13-bit address bus and 8-bit data bus. The CPU fetches 16-bit instructions (3-bit opcode, 13-bit address) as two ROM bytes and executes one instruction every 8 clocks. Memories are preloaded by the bench through hierarchy; the only ports are clock and reset.

Parameters:
CLK_PER_INSTR, 8, clock cycles per instruction; fixed, not overridable.
RAM_DEPTH, 1024, data RAM bytes.
ROM_DEPTH, 8192, program ROM bytes.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  reset, synchronous, active-high (asserted = 1 despite the name).

Behaviour:
- Instances, with hierarchy the bench depends on: cpu (CPU core), cpu.cpu_sm (controller, 3-bit reg state), rom (reg [7:0] mem[0:8191]), ram (reg [7:0] mem[0:1023]).
- Top-level nets: addr[12:0], ram_en, wr. CPU nets: operation[2:0] = ir[15:13], accu[7:0], data[7:0] (internal data bus), alu_out[7:0].
- Address map: ram_en = (addr[12:11] == 2'b11), i.e. 0x1800–0x1FFF, RAM index = addr[9:0] (mirrors every 1K). All other addresses read ROM at addr[12:0]. ROM is read-only; RAM/ROM reads are combinational onto data.
- Instruction byte order: high byte at PC, low byte at PC+1.
- Opcodes: 0 MOV = no-op; 1 SKZ = if accu==0 skip next instruction (PC += 2); 2 ADD accu <= accu+M (mod 256, carry dropped); 3 AND accu <= accu & M; 4 XOR accu <= accu ^ M; 5 LDA accu <= M; 6 STO M <= accu; 7 JMP PC <= ir[12:0]. M = memory at ir[12:0].
- alu_out combinational: ADD/AND/XOR/LDA results as above; all other opcodes pass accu.
- Controller states S0..S7, one clock each, S7 -> S0:
  S0 addr=PC, ir[15:8] <= data, PC++.
  S1 addr=PC, ir[7:0] <= data, PC++.
  S2 decode; addr = ir[12:0] from S2 through S5.
  S3 operand read, operand register <= data.
  S4 execute: ADD/AND/XOR/LDA accu <= alu_out; SKZ with accu==0 PC <= PC+2; JMP PC <= ir[12:0].
  S5 STO only: CPU drives accu onto data, wr=1; RAM writes on this edge if ram_en; writes to ROM range are ignored.
  S6, S7 idle; addr = PC.
- wr high only in S5 of STO; never high during reset.
- PC is 13 bits and wraps 0x1FFF -> 0x0000.
- Reset (sampled on the clock edge): state=S0, PC=0, ir=0, accu=0, wr=0. Memory contents are preserved. Reset mid-instruction aborts it with no RAM write. First fetch occurs on the first edge after rst_n deasserts.

Test Plan:
1. RAM[0]=0x05, RAM[1]=0x03; ROM = B8 00, 58 01, D8 02, E0 06 (LDA 0x1800, ADD 0x1801, STO 0x1802, JMP 0x0006); 2-cycle reset -> ram.mem[2]=0x08 within 24 clocks of reset release; then it stays 0x08 with operation looping at 7.
2. ADD overflow: RAM[0]=0xFF, RAM[1]=0x02 with the same program -> ram.mem[2]=0x01.
3. AND/XOR: RAM[0]=0xF0, RAM[1]=0x3C with opcode 3 and then opcode 4 in place of ADD -> mem[2]=0x30 and 0xCC respectively.
4. SKZ: LDA zero byte, SKZ, STO ->mem[2], ... -> STO skipped, mem[2] unchanged. With a nonzero byte -> STO executes.
5. Reset pulse asserted in S4 of an STO-bearing program -> wr never asserted, PC=0, accu=0, fetch restarts at 0x0000.
6. STO to 0x0002 (ROM range) -> rom.mem unchanged, ram_en=0 in S5.
